fetch_branch_predictor: RTL and testbench

// - Fetch-side partner of the M-stage branch-resolution logic: generates the fetch PC each cycle and predicts taken branches.
// - Predictor is a direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.
// - Consumes the M-stage resolution/redirect, trains the tables, and flushes wrong-path fetches.
// - Drives the predicted-taken bit that travels down the pipe to the branch unit.

---
 rtl/fetch_branch_predictor_if.sv | 37 +++
 rtl/fetch_branch_predictor.sv | 138 +++++++++++++
 tb/tb_fetch_branch_predictor.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_branch_predictor_if.sv
// Fetch/predictor bundle: fetch PC and prediction out, M-stage resolve/redirect in.
// master = pipeline side (drives stall/resolve/redirect); slave = predictor.
interface fetch_branch_predictor_if;
  logic        stall_F;
  logic [31:0] pc_F;
  logic [31:0] pc_plus_F;
  logic        fetch_valid_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        flush_F;
  logic        resolve_valid_M;
  logic [31:0] resolve_pc_M;
  logic        resolve_taken_M;
  logic [31:0] resolve_target_M;
  logic        mispredict_M;
  logic [31:0] redirect_pc_M;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  modport master (
    output stall_F, resolve_valid_M, resolve_pc_M,
    output resolve_taken_M, resolve_target_M,
    output mispredict_M, redirect_pc_M,
    input  pc_F, pc_plus_F, fetch_valid_F,
    input  pred_taken_F, pred_target_F, flush_F,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  stall_F, resolve_valid_M, resolve_pc_M,
    input  resolve_taken_M, resolve_target_M,
    input  mispredict_M, redirect_pc_M,
    output pc_F, pc_plus_F, fetch_valid_F,
    output pred_taken_F, pred_target_F, flush_F,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/fetch_branch_predictor.sv
// Fetch PC generator with 2-bit BHT + tagged BTB, trained from M-stage resolves.
// Ports: clk, rstn (sync, active-low), bp (slave bundle). Macro PERF_CNT_EN adds perf counters.
module fetch_branch_predictor #(
  parameter int          IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic clk,
  input logic rstn,
  fetch_branch_predictor_if.slave bp
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_init_ctr;
  logic [31:0]        r_pc;
  logic [1:0]         r_bht     [N];
  logic               r_btb_v   [N];
  logic [TAG_W-1:0]   r_btb_tag [N];
  logic [31:0]        r_btb_tgt [N];

  logic               w_run;
  logic               w_hit;
  logic               w_pred;
  logic [31:0]        w_tgt;
  logic               w_flush;
  logic [IDX_W-1:0]   w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic [IDX_W-1:0]   w_r_idx;
  logic [TAG_W-1:0]   w_r_tag;
  logic [1:0]         w_bht_old;
  logic [1:0]         w_bht_new;

  assign w_f_idx = r_pc[IDX_W+1:2];
  assign w_f_tag = r_pc[31:IDX_W+2];
  assign w_r_idx = bp.resolve_pc_M[IDX_W+1:2];
  assign w_r_tag = bp.resolve_pc_M[31:IDX_W+2];

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_INIT:  if (&r_init_ctr) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Lookup is gated by RUN so uncleared table contents never leak out.
  always_comb begin
    w_run   = (r_state == S_RUN);
    w_hit   = w_run && r_btb_v[w_f_idx]
              && (r_btb_tag[w_f_idx] == w_f_tag);
    w_pred  = w_hit && r_bht[w_f_idx][1];
    w_tgt   = w_hit ? r_btb_tgt[w_f_idx] : 32'h0;
    w_flush = w_run && bp.mispredict_M;
  end

  assign bp.pc_F          = r_pc;
  assign bp.pc_plus_F     = r_pc + PC_STEP;
  assign bp.fetch_valid_F = w_run;
  assign bp.pred_taken_F  = w_pred;
  assign bp.pred_target_F = w_tgt;
  assign bp.flush_F       = w_flush;

  always_ff @(posedge clk) begin
    if (!rstn)               r_init_ctr <= '0;
    else if (r_state == S_INIT) r_init_ctr <= r_init_ctr + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)                r_pc <= RESET_PC;
    else if (w_run) begin
      if (bp.mispredict_M)    r_pc <= bp.redirect_pc_M;
      else if (bp.stall_F)    r_pc <= r_pc;
      else if (w_pred)        r_pc <= w_tgt;
      else                    r_pc <= r_pc + PC_STEP;
    end
  end

  always_comb begin
    w_bht_old = r_bht[w_r_idx];
    w_bht_new = w_bht_old;
    if (bp.resolve_taken_M) begin
      if (w_bht_old != 2'b11) w_bht_new = w_bht_old + 2'b01;
    end else begin
      if (w_bht_old != 2'b00) w_bht_new = w_bht_old - 2'b01;
    end
  end

  // Tables are plain storage: INIT walks every entry, RUN trains.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (r_state == S_INIT) begin
        r_bht[r_init_ctr]   <= 2'b01;
        r_btb_v[r_init_ctr] <= 1'b0;
      end else if (bp.resolve_valid_M) begin
        r_bht[w_r_idx] <= w_bht_new;
        if (bp.resolve_taken_M) begin
          r_btb_v[w_r_idx]   <= 1'b1;
          r_btb_tag[w_r_idx] <= w_r_tag;
          r_btb_tgt[w_r_idx] <= bp.resolve_target_M;
        end
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_mp;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else if (w_run) begin
      if (bp.resolve_valid_M && r_perf_br != 32'hFFFF_FFFF)
        r_perf_br <= r_perf_br + 32'd1;
      if (bp.mispredict_M && r_perf_mp != 32'hFFFF_FFFF)
        r_perf_mp <= r_perf_mp + 32'd1;
    end
  end

  assign bp.perf_branches    = r_perf_br;
  assign bp.perf_mispredicts = r_perf_mp;
`else
  assign bp.perf_branches    = 32'h0;
  assign bp.perf_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Randomized + directed bench for fetch_branch_predictor against a table-level model.
// Model tracks counters as integers and BTB as arrays; checked every cycle.
module tb_fetch_branch_predictor;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_branch_predictor_if bp();

  fetch_branch_predictor dut (
    .clk  (clk),
    .rstn (rstn),
    .bp   (bp)
  );

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  bit          m_run;
  int          m_ictr;
  logic [31:0] m_pc;
  int          m_bht  [64];
  bit          m_bv   [64];
  logic [31:0] m_btag [64];
  logic [31:0] m_btgt [64];
  longint      m_nbr;
  longint      m_nmp;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic int idx(logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i = idx(pc);
    return m_run && m_bv[i] && (m_btag[i] == (pc >> 8));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_bht[idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_tgt(logic [31:0] pc);
    return m_hit(pc) ? m_btgt[idx(pc)] : 32'h0;
  endfunction

  task automatic model_check();
    longint br = PERF ? m_nbr : 0;
    longint mp = PERF ? m_nmp : 0;
    check("valid",  32'(bp.fetch_valid_F), 32'(m_run));
    check("pc",     bp.pc_F, m_pc);
    check("pcplus", bp.pc_plus_F, m_pc + 32'd4);
    check("pred",   32'(bp.pred_taken_F), 32'(m_pred(m_pc)));
    check("target", bp.pred_target_F, m_tgt(m_pc));
    check("flush",  32'(bp.flush_F), 32'(m_run && bp.mispredict_M));
    check("perf_br", bp.perf_branches, 32'(br));
    check("perf_mp", bp.perf_mispredicts, 32'(mp));
  endtask

  task automatic model_step();
    if (!rstn) begin
      m_run = 0; m_ictr = 0; m_pc = 32'h0; m_nbr = 0; m_nmp = 0;
    end else if (!m_run) begin
      m_bht[m_ictr] = 1;
      m_bv[m_ictr]  = 0;
      m_ictr++;
      if (m_ictr == 64) m_run = 1;
    end else begin
      bit          p = m_pred(m_pc);
      logic [31:0] t = m_tgt(m_pc);
      if (bp.resolve_valid_M) begin
        int i = idx(bp.resolve_pc_M);
        if (bp.resolve_taken_M) begin
          if (m_bht[i] < 3) m_bht[i]++;
          m_bv[i]   = 1;
          m_btag[i] = bp.resolve_pc_M >> 8;
          m_btgt[i] = bp.resolve_target_M;
        end else if (m_bht[i] > 0) m_bht[i]--;
        if (m_nbr < 64'hFFFF_FFFF) m_nbr++;
      end
      if (bp.mispredict_M && m_nmp < 64'hFFFF_FFFF) m_nmp++;
      if (bp.mispredict_M)  m_pc = bp.redirect_pc_M;
      else if (bp.stall_F)  m_pc = m_pc;
      else if (p)           m_pc = t;
      else                  m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.stall_F = 0; bp.resolve_valid_M = 0; bp.resolve_pc_M = 0;
    bp.resolve_taken_M = 0; bp.resolve_target_M = 0;
    bp.mispredict_M = 0; bp.redirect_pc_M = 0;
  endtask

  task automatic redirect(logic [31:0] pc);
    bp.mispredict_M = 1; bp.redirect_pc_M = pc;
    cycle();
    bp.mispredict_M = 0;
  endtask

  task automatic resolve(logic [31:0] pc, bit tk, logic [31:0] tgt, int n);
    bp.resolve_valid_M = 1; bp.resolve_pc_M = pc;
    bp.resolve_taken_M = tk; bp.resolve_target_M = tgt;
    for (int k = 0; k < n; k++) cycle();
    bp.resolve_valid_M = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    cycle(); cycle();
    rstn = 1;
    check("t1_valid0", 32'(bp.fetch_valid_F), 32'd0);
    check("t1_pc0", bp.pc_F, 32'h0);
    for (int k = 0; k < 63; k++) cycle();
    check("t1_init_end", 32'(bp.fetch_valid_F), 32'd0);
    cycle();
    check("t1_valid1", 32'(bp.fetch_valid_F), 32'd1);
    check("t1_pcA", bp.pc_F, 32'h0);
    check("t1_pred", 32'(bp.pred_taken_F), 32'd0);
  endtask

  initial begin
    idle();
    // T1
    do_reset();
    cycle();
    check("t1_pcB", bp.pc_F, 32'h4);
    cycle();
    check("t1_pcC", bp.pc_F, 32'h8);
    // T2
    resolve(32'h40, 1, 32'h100, 2);
    redirect(32'h40);
    check("t2_pred", 32'(bp.pred_taken_F), 32'd1);
    check("t2_tgt", bp.pred_target_F, 32'h100);
    cycle();
    check("t2_pc", bp.pc_F, 32'h100);
    // T3
    bp.stall_F = 1; bp.mispredict_M = 1; bp.redirect_pc_M = 32'h200;
    #1;
    check("t3_flush", 32'(bp.flush_F), 32'd1);
    cycle();
    check("t3_pc", bp.pc_F, 32'h200);
    idle();
    // T4
    resolve(32'h40, 0, 32'h0, 4);
    redirect(32'h40);
    check("t4_pred4", 32'(bp.pred_taken_F), 32'd0);
    resolve(32'h40, 0, 32'h0, 1);
    resolve(32'h40, 1, 32'h100, 1);
    redirect(32'h40);
    check("t4_floor", 32'(bp.pred_taken_F), 32'd0);
    // T5
    resolve(32'h40, 1, 32'h100, 2);
    redirect(32'h40);
    check("t5_own", 32'(bp.pred_taken_F), 32'd1);
    redirect(32'h140);
    check("t5_alias", 32'(bp.pred_taken_F), 32'd0);
    cycle();
    check("t5_pc", bp.pc_F, 32'h144);
    // T6
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bp.resolve_valid_M = 1; bp.resolve_pc_M = 32'(k) << 2;
      bp.resolve_taken_M = 1'(k & 1); bp.resolve_target_M = 32'h300;
      bp.mispredict_M = (k < 3); bp.redirect_pc_M = 32'h300;
      cycle();
    end
    idle();
    check("t6_br", bp.perf_branches, PERF ? 32'd10 : 32'd0);
    check("t6_mp", bp.perf_mispredicts, PERF ? 32'd3 : 32'd0);
    // Random traffic, with rare mid-run resets.
    for (int k = 0; k < 3000; k++) begin
      rstn = ($urandom_range(0, 999) != 0);
      bp.stall_F          = ($urandom_range(0, 3) == 0);
      bp.resolve_valid_M  = ($urandom_range(0, 9) < 3);
      bp.resolve_pc_M     = 32'($urandom_range(0, 127)) << 2;
      bp.resolve_taken_M  = 1'($urandom_range(0, 1));
      bp.resolve_target_M = 32'($urandom_range(0, 127)) << 2;
      bp.mispredict_M     = ($urandom_range(0, 9) == 0);
      bp.redirect_pc_M    = 32'($urandom_range(0, 127)) << 2;
      cycle();
    end
    idle();
    rstn = 1;
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
